stream_fifo: RTL

Parametrised valid/ready FIFO between two `stream` interface modports. It sits on any point-to-point `stream` link, replacing a bare modport-to-modport connection, to add buffering, decouple backpressure and report fill level. It generalises the fixed 32-bit data/valid/ready bundle to a configurable data width, depth and optional fall-through mode, and adds a synchronous flush.

---
 rtl/stream_pkg.sv | 17 +
 rtl/stream.sv | 9 +
 rtl/stream_fifo_mem.sv | 22 ++
 rtl/stream_fifo.sv | 65 ++++++
 4 files changed

// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - sizing and pointer helpers shared by the stream FIFO
package stream_pkg;

  function automatic int ptr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Wraps at an arbitrary depth, so non-power-of-two FIFOs stay dense
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/stream.sv
// rtl/stream.sv - point-to-point valid/ready stream link
interface stream #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport in  (input data, valid, output ready);
  modport out (output data, valid, input ready);
endinterface

// File: rtl/stream_fifo_mem.sv
// rtl/stream_fifo_mem.sv - FIFO storage, one write port, asynchronous read port
module stream_fifo_mem import stream_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
)(
  input  logic                          clk_i,
  input  logic                          we,
  input  logic [ptr_width(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]              wdata,
  input  logic [ptr_width(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]              rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - parametrised valid/ready FIFO with flush and optional fall-through
module stream_fifo import stream_pkg::*; #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 4,
  parameter bit FALL_THROUGH = 1'b0
)(
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  stream.in                             in,
  stream.out                            out,
  output logic [level_width(DEPTH)-1:0] level_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int PW = ptr_width(DEPTH);
  localparam int LW = level_width(DEPTH);

  logic [PW-1:0]    wptr, rptr;
  logic [WIDTH-1:0] rdata;
  logic             bypass, push, pop, we, rd;

  assign full_o  = (level_o == LW'(DEPTH));
  assign empty_o = (level_o == '0);

  // Reset gating keeps out.valid low while rst_ni is held, even in fall-through mode
  assign bypass    = FALL_THROUGH && empty_o && !flush_i && rst_ni;
  assign in.ready  = !full_o && !flush_i;
  assign out.valid = bypass ? in.valid : (!empty_o && !flush_i);
  assign out.data  = bypass ? in.data : rdata;

  assign push = in.valid && in.ready;
  assign pop  = out.valid && out.ready;
  // A beat that bypasses storage is consumed in the same cycle and never written
  assign we   = push && !(bypass && pop);
  assign rd   = pop && !bypass;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr    <= '0;
      rptr    <= '0;
      level_o <= '0;
    end else if (flush_i) begin
      wptr    <= '0;
      rptr    <= '0;
      level_o <= '0;
    end else begin
      if (we) wptr <= PW'(ptr_inc(32'(wptr), DEPTH));
      if (rd) rptr <= PW'(ptr_inc(32'(rptr), DEPTH));
      if (we && !rd)      level_o <= level_o + LW'(1);
      else if (rd && !we) level_o <= level_o - LW'(1);
    end
  end

  stream_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk_i (clk_i),
    .we    (we),
    .waddr (wptr),
    .wdata (in.data),
    .raddr (rptr),
    .rdata (rdata)
  );

endmodule
